// File: rtl/ssd_pkg.sv
// ----------------------------------------------------------------------------
// ssd_pkg
// Shared definitions for the seven-segment display path: the blank digit code
// understood by the digit decoders, the converter FSM state type, the default
// digit count and a helper returning 10^n for range checks.
// ----------------------------------------------------------------------------
package ssd_pkg;

    // Digit code the decoder renders as all segments off.
    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    // Default number of BCD digits on the display.
    localparam int DEFAULT_DIGITS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } conv_state_t;

    // 10^n, evaluated at elaboration time for parameter-derived limits.
    function automatic int pow10(input int n);
        int acc;
        acc = 1;
        for (int i = 0; i < n; i++) begin
            acc = acc * 10;
        end
        return acc;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// ----------------------------------------------------------------------------
// bcd_add3
// Combinational correction step of the shift-and-add-3 algorithm: a digit of
// 5 or more gets 3 added so that the following left shift carries correctly
// into the next decimal digit.
// Ports:
//   digit     in  4  BCD digit before correction
//   corrected out 4  digit after correction
// ----------------------------------------------------------------------------
module bcd_add3 (
    input  logic [3:0] digit,
    output logic [3:0] corrected
);

    always_comb begin
        corrected = digit;
        if (digit >= 4'd5) begin
            corrected = digit + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// ----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3). One conversion per
// start request, fixed length of BIN_W shift cycles. Values >= 10^DIGITS are
// reported through ovf and shown as blank digits.
//
// Optional build macro: BIN2BCD_LEAD_BLANK_EN
//   When defined, leading zero digits are replaced by the blank code; digit 0
//   is never blanked.
//
// Parameters:
//   BIN_W   width of the binary input
//   DIGITS  number of BCD output digits
// Ports:
//   clk_s  in  1          system clock
//   rst_s  in  1          asynchronous active-high reset
//   start  in  1          conversion request, accepted only in IDLE
//   bin    in  BIN_W      unsigned value, captured when start is accepted
//   busy   out 1          conversion in progress (CONV or DONE)
//   done   out 1          one-cycle pulse when bcd/ovf update
//   bcd    out 4*DIGITS   packed BCD result, digit 0 in [3:0]
//   ovf    out 1          last captured value was >= 10^DIGITS
// ----------------------------------------------------------------------------
module bin2bcd_seq
    import ssd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = DEFAULT_DIGITS
) (
    input  logic                  clk_s,
    input  logic                  rst_s,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    // One extra digit of headroom so full-scale inputs never disturb the
    // digits that are actually reported; the top digit is dropped.
    localparam int BCD_W = 4 * (DIGITS + 1);
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int LIMIT = pow10(DIGITS);

    conv_state_t         state_reg, state_next;
    logic [BCD_W-1:0]    bcd_f_reg;
    logic [BIN_W-1:0]    bin_f_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                ovf_pending_reg;
    logic [4*DIGITS-1:0] bcd_reg;
    logic                ovf_reg;
    logic                done_reg;

    logic [BCD_W-1:0]    bcd_corr;
    logic [BCD_W-1:0]    bcd_shift;
    logic [BIN_W-1:0]    bin_shift;
    logic [4*DIGITS-1:0] digits_out;
    logic                last_shift;

    // Per-digit add-3 correction ahead of each shift.
    generate
        for (genvar gi = 0; gi < DIGITS + 1; gi++) begin : g_add3
            bcd_add3 u_add3 (
                .digit     (bcd_f_reg[4*gi +: 4]),
                .corrected (bcd_corr[4*gi +: 4])
            );
        end
    endgenerate

    // Left shift of the combined {BCD field, binary field}.
    assign bcd_shift  = {bcd_corr[BCD_W-2:0], bin_f_reg[BIN_W-1]};
    assign bin_shift  = {bin_f_reg[BIN_W-2:0], 1'b0};
    assign last_shift = (state_reg == CONV) && (cnt_reg == CNT_W'(1));

`ifdef BIN2BCD_LEAD_BLANK_EN
    logic lead_zero;
`endif

    // Result formatting, computed from the final shift so the outputs are
    // already valid during the DONE cycle.
    always_comb begin
        digits_out = bcd_shift[4*DIGITS-1:0];
`ifdef BIN2BCD_LEAD_BLANK_EN
        lead_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lead_zero && (digits_out[4*i +: 4] == 4'd0)) begin
                digits_out[4*i +: 4] = DIGIT_BLANK;
            end else begin
                lead_zero = 1'b0;
            end
        end
`endif
        if (ovf_pending_reg) begin
            digits_out = {DIGITS{DIGIT_BLANK}};
        end
    end

    // FSM state register.
    always_ff @(posedge clk_s or posedge rst_s) begin
        if (rst_s) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = CONV;
                end
            end
            CONV: begin
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk_s or posedge rst_s) begin
        if (rst_s) begin
            bcd_f_reg       <= '0;
            bin_f_reg       <= '0;
            cnt_reg         <= '0;
            ovf_pending_reg <= 1'b0;
            bcd_reg         <= '0;
            ovf_reg         <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        bin_f_reg       <= bin;
                        bcd_f_reg       <= '0;
                        ovf_pending_reg <= (32'(bin) >= LIMIT);
                        cnt_reg         <= CNT_W'(BIN_W);
                    end
                end
                CONV: begin
                    bcd_f_reg <= bcd_shift;
                    bin_f_reg <= bin_shift;
                    cnt_reg   <= cnt_reg - CNT_W'(1);
                    // Loading on the edge into DONE makes the result and the
                    // done pulse coincide with the DONE cycle.
                    if (last_shift) begin
                        bcd_reg  <= digits_out;
                        ovf_reg  <= ovf_pending_reg;
                        done_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = done_reg;
    assign bcd  = bcd_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// ----------------------------------------------------------------------------
// tb_bin2bcd_seq
// Directed self-checking bench for bin2bcd_seq (BIN_W=14, DIGITS=4).
// Expected values are hand-computed; the BIN2BCD_LEAD_BLANK_EN build uses the
// blanked variants.
// ----------------------------------------------------------------------------
module tb_bin2bcd_seq;

    logic        clk_s;
    logic        rst_s;
    logic        start;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        ovf;

    int checks;
    int errors;

    bin2bcd_seq #(
        .BIN_W  (14),
        .DIGITS (4)
    ) dut (
        .clk_s (clk_s),
        .rst_s (rst_s),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf)
    );

    initial clk_s = 1'b0;
    always #5 clk_s = ~clk_s;

`ifdef BIN2BCD_LEAD_BLANK_EN
    localparam logic [15:0] EXP_0   = 16'hFFF0;
    localparam logic [15:0] EXP_5   = 16'hFFF5;
    localparam logic [15:0] EXP_42  = 16'hFF42;
    localparam logic [15:0] EXP_321 = 16'hF321;
`else
    localparam logic [15:0] EXP_0   = 16'h0000;
    localparam logic [15:0] EXP_5   = 16'h0005;
    localparam logic [15:0] EXP_42  = 16'h0042;
    localparam logic [15:0] EXP_321 = 16'h0321;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // One conversion with a single-cycle start; checks latency, result,
    // busy duration and return to idle.
    task automatic run_conv(input string tag, input logic [13:0] v,
                            input logic [15:0] exp_bcd, input logic exp_ovf);
        int n;
        int busy_cycles;
        @(negedge clk_s);
        start = 1'b1;
        bin   = v;
        @(negedge clk_s);
        start = 1'b0;
        n = 1;
        busy_cycles = 0;
        while (done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk_s);
            n++;
        end
        check({tag, "_latency"}, n, 15);
        check({tag, "_busy_cnt"}, busy_cycles, 14);
        check({tag, "_busy_done"}, busy, 1);
        check({tag, "_bcd"}, bcd, exp_bcd);
        check({tag, "_ovf"}, ovf, exp_ovf);
        $display("conv %s bin=%0d bcd=%h ovf=%b cycles=%0d", tag, v, bcd, ovf, n);
        @(negedge clk_s);
        check({tag, "_done_clr"}, done, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        int last_done;
        checks = 0;
        errors = 0;
        rst_s  = 1'b1;
        start  = 1'b0;
        bin    = '0;

        // Reset state
        @(negedge clk_s);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bcd", bcd, 0);
        check("rst_ovf", ovf, 0);
        @(negedge clk_s);
        rst_s = 1'b0;

        run_conv("v1234", 14'd1234, 16'h1234, 1'b0);
        run_conv("v0", 14'd0, EXP_0, 1'b0);
        run_conv("v9999", 14'd9999, 16'h9999, 1'b0);
        run_conv("v10000", 14'd10000, 16'hFFFF, 1'b1);
        run_conv("v16383", 14'd16383, 16'hFFFF, 1'b1);
        run_conv("v5", 14'd5, EXP_5, 1'b0);

        // Start re-pulsed mid-conversion must be ignored.
        @(negedge clk_s);
        start = 1'b1;
        bin   = 14'd42;
        @(negedge clk_s);
        start = 1'b0;
        repeat (4) @(negedge clk_s);
        start = 1'b1;
        bin   = 14'd7777;
        @(negedge clk_s);
        start = 1'b0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1) begin
                pulses++;
                check("ignore_bcd", bcd, EXP_42);
                check("ignore_ovf", ovf, 0);
            end
            @(negedge clk_s);
        end
        check("ignore_pulses", pulses, 1);
        $display("conv ignore bin=42 bcd=%h pulses=%0d", bcd, pulses);

        // Start held high: back-to-back conversions every 16 cycles.
        start = 1'b1;
        bin   = 14'd321;
        pulses = 0;
        last_done = -1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk_s);
            if (done === 1'b1) begin
                pulses++;
                check("held_bcd", bcd, EXP_321);
                if (last_done >= 0) check("held_period", c - last_done, 16);
                last_done = c;
                $display("conv held bin=321 bcd=%h at=%0d", bcd, c);
            end
        end
        check("held_pulses", pulses, 3);
        start = 1'b0;
        repeat (20) @(negedge clk_s);
        check("held_idle", busy, 0);

        // Reset in the middle of a conversion.
        @(negedge clk_s);
        start = 1'b1;
        bin   = 14'd1234;
        @(negedge clk_s);
        start = 1'b0;
        repeat (6) @(negedge clk_s);
        rst_s = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_bcd", bcd, 0);
        check("abort_ovf", ovf, 0);
        check("abort_done", done, 0);
        @(negedge clk_s);
        rst_s = 1'b0;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_s);
            if (done === 1'b1) pulses++;
        end
        check("abort_no_done", pulses, 0);
        $display("conv abort bcd=%h done_pulses=%0d", bcd, pulses);

        run_conv("v2024", 14'd2024, 16'h2024, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
